param_counter: RTL and testbench

Parametrised up/down counter that succeeds the fixed 4-bit enable counter as the team's general-purpose counting primitive. It adds configurable width and modulus, direction control, parallel load, synchronous clear, wrap or saturate behaviour, a terminal-count pulse and a sticky overflow flag. It sits wherever timers, event counters and address sequencers are needed. An optional prescaler can be compiled in.

---
 rtl/param_counter_pkg.sv | 18 +
 rtl/counter_prescaler.sv | 39 +++
 rtl/param_counter.sv | 103 ++++++++++
 tb/tb_param_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for param_counter and its prescaler.
package param_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Prescaler counter width; never narrower than one bit so PRESCALE=1 still elaborates.
    function automatic int presc_width(input int prescale);
        if (prescale <= 2) begin
            return 1;
        end
        return $clog2(prescale);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Counts enabled cycles 0..PRESCALE-1 and asserts tick on the last one.
module counter_prescaler
    import param_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_clr,
    input  logic enable,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = enable && !sync_clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down wrap/saturate counter with load, clear, tc pulse and sticky ovf.
// Define PARAM_COUNTER_PRESCALE_EN to build in the enabled-cycle prescaler.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD      = 256,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // One extra bit keeps MOD-1 representable and comparisons exact when MOD=2**WIDTH.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_OUT = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   out_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_clamped;
    logic             step_tick;

`ifdef PARAM_COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .sync_clr (clear | load),
        .enable   (enable),
        .tick     (step_tick)
    );
`else
    // Without the prescaler every enabled cycle steps; an illegal PRESCALE idles the counter.
    assign step_tick = (PRESCALE >= 1);
`endif

    assign out_ext      = {1'b0, out_q};
    assign load_ext     = {1'b0, load_val};
    assign load_clamped = (load_ext > MAX_EXT) ? MAX_OUT : load_val;

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clear) begin
            out_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            out_d = load_clamped;
        end else if (enable && step_tick) begin
            if (up == DIR_UP) begin
                if (out_ext == MAX_EXT) begin
                    tc_d = 1'b1;
                    if (mode == MODE_WRAP) begin
                        out_d = '0;
                    end
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if (out_q == '0) begin
                    tc_d = 1'b1;
                    if (mode == MODE_WRAP) begin
                        out_d = MAX_OUT;
                    end
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
            ovf_d = ovf_q | tc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter at WIDTH=4, MOD=10, PRESCALE=3.
module tb_param_counter;

    localparam int WIDTH    = 4;
    localparam int MOD      = 10;
    localparam int PRESCALE = 3;
`ifdef PARAM_COUNTER_PRESCALE_EN
    localparam int STEP_CYC = PRESCALE;
`else
    localparam int STEP_CYC = 1;
`endif

    logic             clk = 1'b0;
    logic             rst, enable, up, mode, clear, load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc, ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_counter #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .up       (up),
        .mode     (mode),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .tc       (tc),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        rst = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        idle();
        load = 1'b1; load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; load = 1'b1; load_val = 4'd5;
        up = 1'b1; mode = 1'b0; clear = 1'b0;
        cyc(2);
        chk("reset_out", out, 0);
        chk("reset_tc",  tc, 0);
        chk("reset_ovf", ovf, 0);
        idle();
        cyc(1);
        chk("idle_out", out, 0);

        // Up, wrap: 1..9,0,1,2 with tc only at the 9->0 step
        mode = 1'b0; up = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(STEP_CYC);
            chk($sformatf("upwrap_out%0d", i), out, i % 10);
            chk($sformatf("upwrap_tc%0d", i), tc, (i == 10) ? 1 : 0);
        end
        enable = 1'b0;
        cyc(1);
        chk("hold_out", out, 2);
        chk("hold_tc", tc, 0);
        chk("sticky_ovf", ovf, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clear_out", out, 0);
        chk("clear_ovf", ovf, 0);

        // Down, saturate from 2: 1,0,0,0 with tc on the blocked steps
        do_load(4'd2);
        chk("load2_out", out, 2);
        mode = 1'b1; up = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(STEP_CYC);
            chk($sformatf("dnsat_out%0d", i), out, (i == 1) ? 1 : 0);
            chk($sformatf("dnsat_tc%0d", i), tc, (i >= 3) ? 1 : 0);
        end
        chk("dnsat_ovf", ovf, 1);

        // Load clamps to MOD-1 and beats enable; clear beats load
        idle();
        load = 1'b1; load_val = 4'd15; enable = 1'b1;
        cyc(1);
        chk("clamp_out", out, 9);
        chk("clamp_tc", tc, 0);
        chk("clamp_ovf_kept", ovf, 1);
        clear = 1'b1;
        cyc(1);
        chk("clr_over_load_out", out, 0);
        chk("clr_over_load_ovf", ovf, 0);

        // Prescaler: 9 enabled cycles
        idle();
        mode = 1'b0; up = 1'b1; enable = 1'b1;
        cyc(2);
`ifdef PARAM_COUNTER_PRESCALE_EN
        chk("presc_out_c2", out, 0);
`else
        chk("presc_out_c2", out, 2);
`endif
        cyc(7);
`ifdef PARAM_COUNTER_PRESCALE_EN
        chk("presc_out_c9", out, 3);
`else
        chk("presc_out_c9", out, 9);
`endif

        // Up saturate at MOD-1
        do_load(4'd8);
        mode = 1'b1; up = 1'b1; enable = 1'b1;
        cyc(STEP_CYC);
        chk("upsat_out1", out, 9);
        chk("upsat_tc1", tc, 0);
        cyc(STEP_CYC);
        chk("upsat_out2", out, 9);
        chk("upsat_tc2", tc, 1);

        // Down wrap 0 -> MOD-1
        do_load(4'd0);
        mode = 1'b0; up = 1'b0; enable = 1'b1;
        cyc(STEP_CYC);
        chk("dnwrap_out", out, 9);
        chk("dnwrap_tc", tc, 1);

        // Reset mid-count overrides load and enable
        do_load(4'd6);
        chk("pre_rst_out", out, 6);
        rst = 1'b1; load = 1'b1; load_val = 4'd3; enable = 1'b1;
        cyc(1);
        chk("midrst_out", out, 0);
        chk("midrst_tc", tc, 0);
        chk("midrst_ovf", ovf, 0);
        idle();
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
